cv32e40x_dbg_trace_buf: RTL and testbench
=========================================

// Module: cv32e40x_dbg_trace_buf
// PURPOSE
// - Downstream consumer of the decode-stage debug snapshot (instr, is_compressed, rf_we, rf_waddr, illegal_insn).
// - Records each valid snapshot into a DEPTH-entry circular history buffer.
// - Freezes POST_TRIG records after the first illegal instruction, so the lead-up to the fault can be read back.
// - Read back through a registered index port. Debug/bench aid only; no effect on core datapath.
// PARAMETERS
// - DEPTH      16  entries in ring; power of 2, >= 2
// - POST_TRIG  4   records captured after (not counting) the trigger record; 0..DEPTH-1
// PORTS
// - clk            in   1        core clock; all logic on rising edge
// - rst            in   1        asynchronous, active-high reset
// - valid_i        in   1        snapshot below is valid this cycle
// - instr_i        in   32       instruction word
// - is_compressed_i in  1        instr_i is a 16-bit (compressed) encoding
// - rf_we_i        in   1        instruction writes the register file
// - rf_waddr_i     in   5        destination register address
// - illegal_insn_i in   1        instruction decoded as illegal (trigger source)
// - arm_i          in   1        clear buffer and (re)start capture
// - rd_req_i       in   1        read request
// - rd_idx_i       in   $clog2(DEPTH)  entry index, 0 = oldest valid entry
// - rd_valid_o     out  1        read data valid (1 cycle after rd_req_i)
// - rd_err_o       out  1        with rd_valid_o: rd_idx_i >= count_o at request
// - rd_instr_o     out  32       entry instr
// - rd_flags_o     out  8        {illegal, rf_we, is_compressed, rf_waddr[4:0]}
// - rd_tstamp_o    out  16       entry cycle stamp (see CONFIGURATION)
// - state_o        out  2        0 IDLE, 1 CAPTURE, 2 POST, 3 FROZEN
// - count_o        out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
// BEHAVIOUR
// - Reset values
//   - state IDLE; wr_ptr, count_o, post counter, timestamp = 0.
//   - All rd_* outputs = 0.
//   - Array contents undefined, but never readable before written (guarded by count_o).
// - IDLE: ignore valid_i. arm_i -> CAPTURE.
// - Write rule (CAPTURE or POST, valid_i=1)
//   - mem[wr_ptr] <= record; wr_ptr <= wr_ptr+1 (wraps mod DEPTH).
//   - count_o <= min(count_o+1, DEPTH).
//   - When full, the oldest entry is overwritten.
// - CAPTURE, valid_i & illegal_insn_i
//   - Trigger record is written.
//   - POST_TRIG==0 -> FROZEN; else -> POST with post counter = POST_TRIG.
// - POST
//   - Each written record decrements the post counter; the write that takes it to 0 -> FROZEN (same edge).
//   - illegal_insn_i in POST does not retrigger.
// - FROZEN: no writes; hold until arm_i.
// - arm_i
//   - From any state: wr_ptr, count_o, post counter, timestamp <= 0; state <= CAPTURE.
//   - arm_i wins over a same-cycle valid_i; that record is dropped.
// - Read
//   - rd_req_i sampled at cycle N -> rd_valid_o=1 for exactly cycle N+1.
//   - Physical address = (count_o<DEPTH ? 0 : wr_ptr) + rd_idx_i, mod DEPTH; pointer/count taken at cycle N.
//   - Read data = array content before any write in cycle N (read-before-write).
//   - rd_idx_i >= count_o -> rd_err_o=1 and rd_instr_o/flags/tstamp = 0.
//   - No rd_req_i -> rd_valid_o=0; data outputs hold last value.
//   - Reads are legal in every state; the result is deterministic even while capturing.
// - Reset mid-operation: immediate return to reset values; capture not resumed until arm_i.
// CONFIGURATION
// - CV32E40X_DBG_TRACE_TSTAMP_EN defined
//   - 16-bit free-running cycle counter; resets to 0, cleared by arm_i, wraps 0xFFFF->0.
//   - Counter value is stored with each entry and returned on rd_tstamp_o.
// - Not defined: no counter or stamp storage; rd_tstamp_o tied to 0. Port list unchanged.
// TESTING
// - Reset, then valid_i x3 without arm_i -> count_o=0, state_o=0; rd_req idx0 -> rd_err_o=1.
// - arm_i, then 5 valid records instr=0x100..0x104 -> count_o=5; rd idx0 -> 0x100, idx4 -> 0x104, idx5 -> rd_err_o=1.
// - DEPTH=16, arm_i, 20 records 0x0..0x13 -> count_o=16; idx0 -> 0x4, idx15 -> 0x13.
// - POST_TRIG=4, illegal at record 7, then 10 more
//   -> state_o=3 after record 11; count_o=12; idx7 flags[7]=1; idx11 = record 11.
// - Same cycle arm_i & valid_i in FROZEN -> state_o=1, count_o=0; next lone valid lands at idx0.
// - TSTAMP_EN, arm_i at cycle 0, valid at cycles 3 and 70000 -> stamps 3 and 70000 mod 65536 = 4464; macro off -> 0.

Source files
------------

// File: rtl/cv32e40x_dbg_trace_buf.sv
// Circular history of decode-stage snapshots, frozen POST_TRIG records after an illegal insn.
// Optional per-entry cycle stamps: define CV32E40X_DBG_TRACE_TSTAMP_EN.
module cv32e40x_dbg_trace_buf #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [31:0]              instr_i,
  input  logic                     is_compressed_i,
  input  logic                     rf_we_i,
  input  logic [4:0]               rf_waddr_i,
  input  logic                     illegal_insn_i,
  input  logic                     arm_i,
  input  logic                     rd_req_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic                     rd_valid_o,
  output logic                     rd_err_o,
  output logic [31:0]              rd_instr_o,
  output logic [7:0]               rd_flags_o,
  output logic [15:0]              rd_tstamp_o,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PT = AW'(POST_TRIG);

`ifdef CV32E40X_DBG_TRACE_TSTAMP_EN
  localparam int RW = 56;
`else
  localparam int RW = 40;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    FROZEN  = 2'd3
  } state_t;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   post_cnt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_addr;
  logic            rd_bad;
  logic            we;
  logic [RW-1:0]   rec;
  logic [RW-1:0]   mem [DEPTH];

  assign we = valid_i && !arm_i && (state == CAPTURE || state == POST);
  assign rd_bad = {1'b0, rd_idx_i} >= count;
  assign rd_addr = (count == FULL ? wr_ptr : '0) + rd_idx_i;
  assign state_o = state;
  assign count_o = count;

`ifdef CV32E40X_DBG_TRACE_TSTAMP_EN
  logic [15:0] tstamp;
  logic [15:0] rd_ts;

  assign rec = {tstamp, illegal_insn_i, rf_we_i, is_compressed_i,
                rf_waddr_i, instr_i};
  assign rd_tstamp_o = rd_ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tstamp <= '0;
      rd_ts  <= '0;
    end else begin
      tstamp <= arm_i ? 16'd0 : tstamp + 16'd1;
      if (rd_req_i)
        rd_ts <= rd_bad ? 16'd0 : mem[rd_addr][55:40];
    end
  end
`else
  assign rec = {illegal_insn_i, rf_we_i, is_compressed_i,
                rf_waddr_i, instr_i};
  assign rd_tstamp_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_ptr] <= rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      post_cnt <= '0;
      count    <= '0;
    end else if (arm_i) begin
      state    <= CAPTURE;
      wr_ptr   <= '0;
      post_cnt <= '0;
      count    <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != FULL)
          count <= count + 1'b1;
      end
      unique case (state)
        CAPTURE: begin
          if (valid_i && illegal_insn_i) begin
            if (POST_TRIG == 0) begin
              state <= FROZEN;
            end else begin
              state    <= POST;
              post_cnt <= PT;
            end
          end
        end
        POST: begin
          if (valid_i) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1))
              state <= FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  // Read sees pre-write contents because mem updates on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_o <= 1'b0;
      rd_err_o   <= 1'b0;
      rd_instr_o <= '0;
      rd_flags_o <= '0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) begin
        rd_err_o <= rd_bad;
        if (rd_bad) begin
          rd_instr_o <= '0;
          rd_flags_o <= '0;
        end else begin
          rd_instr_o <= mem[rd_addr][31:0];
          rd_flags_o <= mem[rd_addr][39:32];
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_dbg_trace_buf.sv
// Bench for cv32e40x_dbg_trace_buf: scoreboard of expected read results.
module tb_cv32e40x_dbg_trace_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] instr = '0;
  logic        is_c = 1'b0;
  logic        rf_we = 1'b0;
  logic [4:0]  waddr = '0;
  logic        illegal = 1'b0;
  logic        arm = 1'b0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_idx = '0;
  logic        rd_valid;
  logic        rd_err;
  logic [31:0] rd_instr;
  logic [7:0]  rd_flags;
  logic [15:0] rd_tstamp;
  logic [1:0]  state;
  logic [4:0]  count;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic        err;
    logic [31:0] instr;
    logic [7:0]  flags;
    logic        ts_chk;
    logic [15:0] ts;
  } exp_t;

  exp_t sb[$];

  cv32e40x_dbg_trace_buf #(.DEPTH(16), .POST_TRIG(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid), .instr_i(instr),
    .is_compressed_i(is_c), .rf_we_i(rf_we), .rf_waddr_i(waddr),
    .illegal_insn_i(illegal), .arm_i(arm), .rd_req_i(rd_req),
    .rd_idx_i(rd_idx), .rd_valid_o(rd_valid), .rd_err_o(rd_err),
    .rd_instr_o(rd_instr), .rd_flags_o(rd_flags),
    .rd_tstamp_o(rd_tstamp), .state_o(state), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fl(input logic [31:0] ins,
                                    input logic ill);
    return {ill, ins[0], ins[1], ins[6:2]};
  endfunction

  task automatic rec(input logic [31:0] ins, input logic ill);
    valid = 1'b1;
    instr = ins;
    rf_we = ins[0];
    is_c = ins[1];
    waddr = ins[6:2];
    illegal = ill;
    step();
    valid = 1'b0;
    illegal = 1'b0;
  endtask

  task automatic arm_p();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic rd(input int idx, input logic err,
                    input logic [31:0] ins, input logic ill,
                    input logic tc, input logic [15:0] ts);
    exp_t e;
    e.err = err;
    e.instr = err ? 32'd0 : ins;
    e.flags = err ? 8'd0 : fl(ins, ill);
    e.ts_chk = tc | err;
    e.ts = err ? 16'd0 : ts;
    sb.push_back(e);
    rd_req = 1'b1;
    rd_idx = idx[3:0];
    step();
    rd_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_err", rd_err, e.err);
        chk("rd_instr", rd_instr, e.instr);
        chk("rd_flags", rd_flags, e.flags);
        if (e.ts_chk) chk("rd_tstamp", rd_tstamp, e.ts);
      end
    end
  end

  initial begin
    logic [15:0] ts0;
    logic [15:0] ts1;
`ifdef CV32E40X_DBG_TRACE_TSTAMP_EN
    ts0 = 16'd3;
    ts1 = 16'd4464;
`else
    ts0 = 16'd0;
    ts1 = 16'd0;
`endif
    step();
    step();
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_instr", rd_instr, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++) rec(32'h50 + i, 1'b0);
    chk("idle_count", count, 0);
    chk("idle_state", state, 0);
    rd(0, 1'b1, 0, 1'b0, 1'b0, 0);

    arm_p();
    chk("arm_state", state, 1);
    for (int i = 0; i < 5; i++) rec(32'h100 + i, 1'b0);
    chk("five_count", count, 5);
    rd(0, 1'b0, 32'h100, 1'b0, 1'b0, 0);
    rd(4, 1'b0, 32'h104, 1'b0, 1'b0, 0);
    rd(5, 1'b1, 0, 1'b0, 1'b0, 0);

    arm_p();
    for (int i = 0; i < 20; i++) rec(i, 1'b0);
    chk("wrap_count", count, 16);
    rd(0, 1'b0, 32'h4, 1'b0, 1'b0, 0);
    rd(15, 1'b0, 32'h13, 1'b0, 1'b0, 0);
    rd(7, 1'b0, 32'hb, 1'b0, 1'b0, 0);

    arm_p();
    for (int i = 0; i < 22; i++) begin
      rec(32'h200 + i, (i == 7) || (i == 9));
      if (i == 7) chk("trig_state", state, 2);
      if (i == 10) chk("post_state", state, 2);
      if (i == 11) chk("frozen_state", state, 3);
    end
    chk("frozen_count", count, 12);
    chk("frozen_hold", state, 3);
    rd(7, 1'b0, 32'h207, 1'b1, 1'b0, 0);
    rd(9, 1'b0, 32'h209, 1'b1, 1'b0, 0);
    rd(11, 1'b0, 32'h20b, 1'b0, 1'b0, 0);
    rd(12, 1'b1, 0, 1'b0, 1'b0, 0);

    arm = 1'b1;
    rec(32'hdead, 1'b0);
    arm = 1'b0;
    chk("rearm_state", state, 1);
    chk("rearm_count", count, 0);
    rec(32'habc, 1'b0);
    chk("rearm_count1", count, 1);
    rd(0, 1'b0, 32'habc, 1'b0, 1'b0, 0);
    rd(1, 1'b1, 0, 1'b0, 1'b0, 0);
    step();

    rst = 1'b1;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_count", count, 0);
    chk("midrst_rd_instr", rd_instr, 0);
    step();
    rst = 1'b0;
    rec(32'h77, 1'b0);
    chk("midrst_nocap", count, 0);

    arm_p();
    repeat (3) step();
    rec(32'h55, 1'b0);
    repeat (69996) step();
    rec(32'h66, 1'b0);
    rd(0, 1'b0, 32'h55, 1'b0, 1'b1, ts0);
    rd(1, 1'b0, 32'h66, 1'b0, 1'b1, ts1);
    step();
    step();
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
